// File: rtl/acc_cpu_sequencer.sv
// acc_cpu_sequencer: fetch/decode/execute controller for the accumulator CPU.
// Owns PC, IR, MBR and AC; drives a one-cycle-latency RAM and a combinational ALU.
module acc_cpu_sequencer #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h100,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] alu_left,
  output logic [DATA_WIDTH-1:0] alu_right,
  output logic [3:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  halted,
  output logic                  illegal,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic [31:0]           retired
);
  typedef enum logic [3:0] {
    IDLE, FETCH, FETCH_WAIT, DECODE, OPER_RD, OPER_WAIT, EXEC, OPER_WR, HALTED
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d, mbr_q, mbr_d, ac_q, ac_d;
  logic                  illegal_q, illegal_d;
  logic [31:0]           retired_q, retired_d;
  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic                  ac_neg, ac_zero, skip_take;

  assign opcode  = ir_q[DATA_WIDTH-1 -: 4];
  assign operand = ir_q[ADDR_WIDTH-1:0];
  assign ac_neg  = ac_q[DATA_WIDTH-1];
  assign ac_zero = ac_q == '0;
  // Condition in IR[27:26]: 00 negative, 01 zero, 10 positive, 11 never.
  assign skip_take = ir_q[27:26] == 2'd0 ? ac_neg :
                     ir_q[27:26] == 2'd1 ? ac_zero :
                     ir_q[27:26] == 2'd2 ? !ac_neg && !ac_zero : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mbr_q     <= '0;
      ac_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mbr_q     <= mbr_d;
      ac_q      <= ac_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mbr_d       = mbr_q;
    ac_d        = ac_q;
    illegal_d   = illegal_q;
    retired_d   = retired_q;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    mem_oe      = 1'b0;
    mem_addr    = pc_q;
    mem_wdata   = ac_q;
    alu_control = ALU_ADD;
    case (state_q)
      IDLE: state_d = start ? FETCH : IDLE;
      FETCH: begin
        mem_cs  = 1'b1;
        mem_oe  = 1'b1;
        state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = DECODE;
      end
      DECODE: begin
        state_d = FETCH;
        case (opcode)
          4'd0, 4'd2, 4'd3: state_d = OPER_RD;
          4'd1: state_d = OPER_WR;
          4'd4: begin
            pc_d      = skip_take ? pc_q + ADDR_WIDTH'(1) : pc_q;
            retired_d = retired_q + 32'd1;
          end
          4'd5: begin
            pc_d      = operand;
            retired_d = retired_q + 32'd1;
          end
          4'd6: begin
            ac_d      = '0;
            retired_d = retired_q + 32'd1;
          end
          4'd7: begin
            state_d   = HALTED;
            retired_d = retired_q + 32'd1;
          end
          default: begin
            state_d   = HALTED;
            illegal_d = 1'b1;
          end
        endcase
      end
      OPER_RD: begin
        mem_addr = operand;
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        state_d  = OPER_WAIT;
      end
      OPER_WAIT: begin
        mbr_d     = mem_rdata;
        ac_d      = opcode == 4'd0 ? mem_rdata : ac_q;
        retired_d = opcode == 4'd0 ? retired_q + 32'd1 : retired_q;
        state_d   = opcode == 4'd0 ? FETCH : EXEC;
      end
      EXEC: begin
        alu_control = opcode == 4'd3 ? ALU_SUB : ALU_ADD;
        ac_d        = alu_out;
        retired_d   = retired_q + 32'd1;
        state_d     = FETCH;
      end
      OPER_WR: begin
        mem_addr  = operand;
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        retired_d = retired_q + 32'd1;
        state_d   = FETCH;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  assign alu_left  = ac_q;
  assign alu_right = mbr_q;
  assign halted    = state_q == HALTED;
  assign illegal   = illegal_q;
  assign pc_out    = pc_q;
  assign ac_out    = ac_q;
  assign retired   = retired_q;
endmodule

// File: doc/acc_cpu_sequencer.md
Name: acc_cpu_sequencer

Overview:
- Synthesizable fetch/decode/execute controller for the accumulator CPU.
- Owns PC, IR, MBR and AC, and sequences the single-port synchronous RAM (one-cycle read latency) and the combinational 32-bit ALU.
- Replaces bench-driven sequencing; sits between the RAM, the ALU and the top-level start/status logic.
- Instruction format: [31:28] opcode, [27:0] operand address.

Parameters:
ADDR_WIDTH, 28, RAM address width; PC width
DATA_WIDTH, 32, word width of AC, IR, MBR, RAM data and ALU
RESET_PC, 'h100, PC value after reset
ALU_ADD, 4'b0010, ALU control code for add
ALU_SUB, 4'b0110, ALU control code for subtract

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin execution from IDLE; ignored in all other states
mem_addr  out  ADDR_WIDTH  RAM address
mem_cs  out  1  RAM chip select
mem_we  out  1  RAM write enable
mem_oe  out  1  RAM output enable
mem_wdata  out  DATA_WIDTH  write data (top level drives it onto the bus when !mem_oe)
mem_rdata  in  DATA_WIDTH  RAM read data
alu_left  out  DATA_WIDTH  ALU left operand = AC
alu_right  out  DATA_WIDTH  ALU right operand = MBR
alu_control  out  4  ALU mode select
alu_out  in  DATA_WIDTH  ALU result
halted  out  1  sticky: HALT or illegal opcode executed
illegal  out  1  sticky: illegal opcode decoded
pc_out  out  ADDR_WIDTH  current PC
ac_out  out  DATA_WIDTH  current AC
retired  out  32  count of completed legal instructions

Behaviour:
- Reset (async, immediate): state=IDLE, PC=RESET_PC, AC=IR=MBR=0, halted=illegal=0, retired=0.
- Memory controls and alu_control are Moore outputs decoded from state, so reset mid-write drops mem_we in the same cycle.
- Default outputs in every state not listed: mem_cs=mem_we=mem_oe=0, mem_addr=PC, alu_control=ALU_ADD, mem_wdata=AC.
- Opcodes:
  - 0 LOAD: AC<=M[a]
  - 1 STORE: M[a]<=AC
  - 2 ADD: AC<=AC+M[a]
  - 3 SUB: AC<=AC-M[a]
  - 4 SKIP: IR[27:26] selects the condition: 00 AC<0 (signed), 01 AC==0, 10 AC>0 (signed), 11 never. If the condition holds, PC<=PC+1.
  - 5 JUMP: PC<=a[ADDR_WIDTH-1:0]
  - 6 CLEAR: AC<=0
  - 7 HALT
  - 8-F illegal
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: mem_addr=PC, cs=1, oe=1 -> FETCH_WAIT.
  - FETCH_WAIT: IR<=mem_rdata; PC<=PC+1, wrapping mod 2^ADDR_WIDTH -> DECODE.
  - DECODE:
    - LOAD/ADD/SUB -> OPER_RD.
    - STORE -> OPER_WR.
    - SKIP/JUMP/CLEAR: apply the update -> FETCH.
    - HALT -> HALTED.
    - Illegal -> HALTED with illegal<=1.
  - OPER_RD: mem_addr=IR[27:0], cs=1, oe=1 -> OPER_WAIT.
  - OPER_WAIT: MBR<=mem_rdata. LOAD: AC<=mem_rdata -> FETCH. ADD/SUB -> EXEC.
  - EXEC: alu_control=ALU_ADD or ALU_SUB; AC<=alu_out -> FETCH.
  - OPER_WR: mem_addr=IR[27:0], cs=1, we=1, oe=0, mem_wdata=AC -> FETCH.
  - HALTED: terminal until rst; start ignored; no memory access.
- Latency from entering FETCH to next FETCH (or HALTED): SKIP/JUMP/CLEAR/HALT 3 cycles, STORE 4, LOAD 5, ADD/SUB 6.
- retired increments by 1 on the DECODE/OPER_WAIT/EXEC/OPER_WR cycle that completes a legal instruction, HALT included. Illegal opcodes are not counted. Wraps at 2^32.
- Arithmetic: ALU overflow is ignored; AC takes the low DATA_WIDTH bits.
- SKIP at the top address and a PC increment wrap to 0.
- JUMP takes effect at the next FETCH; a JUMP to itself loops indefinitely.
- A start pulse held high while running has no effect.
- At most one RAM access per cycle; mem_we and mem_oe are never both 1.

Test Plan:
- LOAD/ADD/STORE/HALT:
  - Stimulus: M[100]=0x00000110, M[101]=0x20000111, M[102]=0x10000112, M[103]=0x70000000, M[110]=5, M[111]=7; pulse start.
  - Required: M[112]=12, ac_out=12, halted=1 exactly 18 cycles after FETCH entry, retired=4, pc_out=0x104.
- SUB/SKIP:
  - Stimulus: AC=3; SUB of a word equal to 4; then SKIP 0x40000000 (cond 00).
  - Required: AC=0xFFFFFFFF; the following instruction is skipped, so PC advances by 2.
- JUMP/CLEAR loop:
  - Stimulus: CLEAR at 0x100, JUMP 0x50000100 at 0x101.
  - Required: PC alternates 0x100/0x101, AC stays 0, retired increments every 3 cycles.
- Illegal opcode:
  - Stimulus: word 0xF0000000 at 0x100.
  - Required: halted=1, illegal=1, retired=0, no mem_we ever; start pulse afterwards is ignored.
- Reset mid-operation:
  - Stimulus: assert rst during OPER_WR of a STORE.
  - Required: mem_we=0 the same cycle, target word unchanged, pc_out=0x100, state IDLE.
